// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture controller: counter width default,
// FSM state encodings and trigger-mode codes.
package adc_capture_ctrl_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    localparam logic [1:0] TRIG_RISING  = 2'b00;
    localparam logic [1:0] TRIG_FALLING = 2'b01;
    localparam logic [1:0] TRIG_HIGH    = 2'b10;
    localparam logic [1:0] TRIG_LOW     = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_DELAY   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic logic mode_inverts(input logic [1:0] mode);
        return (mode == TRIG_FALLING) || (mode == TRIG_LOW);
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Capture handshake between the controller (master) and the sample FIFO (slave).
interface adc_capture_ctrl_if;

    logic adc_capture_go_o;
    logic adc_trig_status_o;
    logic adc_capture_stop_i;

    modport master (
        output adc_capture_go_o,
        output adc_trig_status_o,
        input  adc_capture_stop_i
    );

    modport slave (
        input  adc_capture_go_o,
        input  adc_trig_status_o,
        output adc_capture_stop_i
    );

endinterface

// File: rtl/adc_capture_ctrl_trig_qualify.sv
// Trigger synchroniser, edge detector and mode qualifier; the qualified pulse
// and level are registered, one cycle behind the sync register.
module trig_qualify
    import adc_capture_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       trig_i,
    input  logic [1:0] mode_i,
    output logic       pulse_o,
    output logic       level_o
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;
    logic level_q, level_d;

    always_comb begin
        sync_d  = trig_i;
        prev_d  = sync_q;
        level_d = sync_q ^ mode_inverts(mode_i);
        case (mode_i)
            TRIG_RISING:  pulse_d = sync_q & ~prev_q;
            TRIG_FALLING: pulse_d = ~sync_q & prev_q;
            TRIG_HIGH:    pulse_d = sync_q;
            default:      pulse_d = ~sync_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: IDLE -> ARMED -> (DELAY) -> CAPTURE -> DONE -> IDLE.
// Define TRIG_TIMEOUT_EN to build the forced-trigger timeout in ARMED.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic               adc_sampleclk,
    input  logic               reset_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               trigger_i,
    input  logic [1:0]         trig_mode_i,
    input  logic [CNT_W-1:0]   trig_delay_i,
    input  logic [CNT_W-1:0]   max_samples_i,
    input  logic [CNT_W-1:0]   trig_timeout_i,
    adc_capture_ctrl_if.master fifo,
    output logic               armed_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   samples_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic             arm_prev_q, arm_prev_d;
    logic             go_q, go_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] samples_q, samples_d;
    logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [1:0]       mode_q, mode_d;
    logic             trig_pulse, trig_level, force_trig;

    // Fed with the next mode so the first ARMED cycle is already qualified
    // with the newly latched mode rather than the previous capture's.
    trig_qualify u_trig_qualify (
        .clk     (adc_sampleclk),
        .rst     (reset_i),
        .trig_i  (trigger_i),
        .mode_i  (mode_d),
        .pulse_o (trig_pulse),
        .level_o (trig_level)
    );

`ifdef TRIG_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_ARMED) tmo_cnt_d = tmo_cnt_q + CNT_ONE;
    end

    always_ff @(posedge adc_sampleclk) begin
        if (reset_i) tmo_cnt_q <= '0;
        else         tmo_cnt_q <= tmo_cnt_d;
    end

    assign force_trig = (trig_timeout_i != '0) && (tmo_cnt_q + CNT_ONE == trig_timeout_i);
`else
    logic unused_trig_timeout;
    assign unused_trig_timeout = ^trig_timeout_i;
    assign force_trig = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        arm_prev_d  = arm_i;
        done_d      = done_q;
        timeout_d   = timeout_q;
        samples_d   = samples_q;
        delay_cnt_d = delay_cnt_q;
        delay_d     = delay_q;
        max_d       = max_q;
        mode_d      = mode_q;

        if (go_q && (samples_q != '1)) samples_d = samples_q + CNT_ONE;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (arm_i && !arm_prev_q) begin
                    state_d   = ST_ARMED;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    samples_d = '0;
                    delay_d   = trig_delay_i;
                    max_d     = max_samples_i;
                    mode_d    = trig_mode_i;
                end
                ST_ARMED: if (trig_pulse || force_trig) begin
                    timeout_d   = !trig_pulse;
                    delay_cnt_d = '0;
                    if (max_q == '0)        state_d = ST_DONE;
                    else if (delay_q == '0) state_d = ST_CAPTURE;
                    else                    state_d = ST_DELAY;
                end
                ST_DELAY: begin
                    if (delay_cnt_q + CNT_ONE == delay_q) state_d = ST_CAPTURE;
                    else delay_cnt_d = delay_cnt_q + CNT_ONE;
                end
                ST_CAPTURE: begin
                    if (fifo.adc_capture_stop_i || (samples_q + CNT_ONE == max_q))
                        state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        go_d = (state_d == ST_CAPTURE);
        if (state_d == ST_DONE) done_d = 1'b1;
    end

    always_ff @(posedge adc_sampleclk) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            arm_prev_q  <= 1'b0;
            go_q        <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            samples_q   <= '0;
            delay_cnt_q <= '0;
            delay_q     <= '0;
            max_q       <= '0;
            mode_q      <= '0;
        end else begin
            state_q     <= state_d;
            arm_prev_q  <= arm_prev_d;
            go_q        <= go_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            samples_q   <= samples_d;
            delay_cnt_q <= delay_cnt_d;
            delay_q     <= delay_d;
            max_q       <= max_d;
            mode_q      <= mode_d;
        end
    end

    assign fifo.adc_capture_go_o  = go_q;
    assign fifo.adc_trig_status_o = trig_level;
    assign armed_o                = (state_q == ST_ARMED);
    assign done_o                 = done_q;
    assign timeout_o              = timeout_q;
    assign samples_o              = samples_q;

endmodule
